// File: rtl/linear_interp_weight_loader_pkg.sv
// Shared constants for the interpolator weight loader: table geometry and FSM encoding.
package linear_interp_weight_loader_pkg;

  localparam int LIW_WEIGHT_WIDTH = 10;
  localparam int NUM_WEIGHTS      = 8;
  localparam int IDX_WIDTH        = 3;

  // Loader FSM encoding (kept as plain constants for legacy tool flows)
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b01;
  localparam logic [1:0] ST_PEND = 2'b10;

  // Index of the final beat of a burst; accepting it closes the burst
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_WEIGHTS - 1);

endpackage

// File: rtl/linear_interp_weight_regfile.sv
// Shadow/active weight storage: indexed writes into the shadow table and a
// single-edge parallel copy of the whole shadow table into the active table.
module linear_interp_weight_regfile
  import linear_interp_weight_loader_pkg::*;
#(
  parameter int WEIGHT_WIDTH = LIW_WEIGHT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_wr_en,
  input  logic [IDX_WIDTH-1:0]    i_wr_idx,
  input  logic [WEIGHT_WIDTH-1:0] i_wr_data,
  input  logic                    i_commit_en,
  output logic [WEIGHT_WIDTH-1:0] o_active [NUM_WEIGHTS]
);

  logic [WEIGHT_WIDTH-1:0] shadow_q [NUM_WEIGHTS];
  logic [WEIGHT_WIDTH-1:0] shadow_d [NUM_WEIGHTS];
  logic [WEIGHT_WIDTH-1:0] active_q [NUM_WEIGHTS];
  logic [WEIGHT_WIDTH-1:0] active_d [NUM_WEIGHTS];

  // Next shadow contents: only the addressed entry changes on a write
  always_comb begin
    shadow_d = shadow_q;
    if (i_wr_en) begin
      shadow_d[i_wr_idx] = i_wr_data;
    end else begin
      shadow_d = shadow_q;
    end
  end

  // Next active contents: whole table swaps at once so readers never see a mix
  always_comb begin
    active_d = active_q;
    if (i_commit_en) begin
      active_d = shadow_q;
    end else begin
      active_d = active_q;
    end
  end

  // Storage flops; reset clears both tables immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_WEIGHTS; k++) begin
        shadow_q[k] <= {WEIGHT_WIDTH{1'b0}};
        active_q[k] <= {WEIGHT_WIDTH{1'b0}};
      end
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign o_active = active_q;

endmodule

// File: rtl/linear_interp_weight_loader.sv
// Writer side of the 2D interpolator weight interface: streams 8 weights into a
// shadow table and publishes them atomically to the active outputs on commit.
module linear_interp_weight_loader
  import linear_interp_weight_loader_pkg::*;
#(
  parameter int WEIGHT_WIDTH = LIW_WEIGHT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [WEIGHT_WIDTH-1:0] i_data,
  input  logic                    i_commit,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_table_valid,
  output logic [WEIGHT_WIDTH-1:0] o_weight0,
  output logic [WEIGHT_WIDTH-1:0] o_weight1,
  output logic [WEIGHT_WIDTH-1:0] o_weight2,
  output logic [WEIGHT_WIDTH-1:0] o_weight3,
  output logic [WEIGHT_WIDTH-1:0] o_weight4,
  output logic [WEIGHT_WIDTH-1:0] o_weight5,
  output logic [WEIGHT_WIDTH-1:0] o_weight6,
  output logic [WEIGHT_WIDTH-1:0] o_weight7
);

  logic [1:0]              state_q, state_d;
  logic [IDX_WIDTH-1:0]    idx_q, idx_d;
  logic                    done_q, done_d;
  logic                    table_valid_q, table_valid_d;
  logic                    wr_en_s;
  logic                    commit_en_s;
  logic [WEIGHT_WIDTH-1:0] active_s [NUM_WEIGHTS];

  // FSM next-state and handshake; abort has priority over beats and commits
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    done_d        = 1'b0;
    table_valid_d = table_valid_q;
    wr_en_s       = 1'b0;
    commit_en_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_LOAD;
          idx_d   = {IDX_WIDTH{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (i_abort) begin
          state_d = ST_IDLE;
          idx_d   = {IDX_WIDTH{1'b0}};
        end else if (i_valid) begin
          wr_en_s = 1'b1;
          idx_d   = idx_q + IDX_WIDTH'(1);
          if (idx_q == LAST_IDX) begin
            state_d = ST_PEND;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_PEND: begin
        if (i_abort) begin
          state_d = ST_IDLE;
          idx_d   = {IDX_WIDTH{1'b0}};
        end else if (i_commit) begin
          commit_en_s   = 1'b1;
          done_d        = 1'b1;
          table_valid_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          state_d = ST_PEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = {IDX_WIDTH{1'b0}};
      end
    endcase
  end

  // Control state flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= {IDX_WIDTH{1'b0}};
      done_q        <= 1'b0;
      table_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      done_q        <= done_d;
      table_valid_q <= table_valid_d;
    end
  end

  linear_interp_weight_regfile #(
    .WEIGHT_WIDTH (WEIGHT_WIDTH)
  ) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .i_wr_en     (wr_en_s),
    .i_wr_idx    (idx_q),
    .i_wr_data   (i_data),
    .i_commit_en (commit_en_s),
    .o_active    (active_s)
  );

  assign o_ready       = (state_q == ST_LOAD);
  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = done_q;
  assign o_table_valid = table_valid_q;
  assign o_weight0     = active_s[0];
  assign o_weight1     = active_s[1];
  assign o_weight2     = active_s[2];
  assign o_weight3     = active_s[3];
  assign o_weight4     = active_s[4];
  assign o_weight5     = active_s[5];
  assign o_weight6     = active_s[6];
  assign o_weight7     = active_s[7];

endmodule

// File: tb/tb_linear_interp_weight_loader.sv
// Directed self-checking bench for linear_interp_weight_loader with a commit scoreboard.
module tb_linear_interp_weight_loader;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start, i_abort, i_valid, i_commit;
  logic [W-1:0] i_data;
  logic         o_ready, o_busy, o_done, o_table_valid;
  logic [W-1:0] o_weight0, o_weight1, o_weight2, o_weight3;
  logic [W-1:0] o_weight4, o_weight5, o_weight6, o_weight7;
  logic [W-1:0] w_s [8];

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;
  logic [8*W-1:0] exp_q [$];
  logic [8*W-1:0] model;
  logic [8*W-1:0] v1, v2, v3, v4, v5;

  linear_interp_weight_loader #(.WEIGHT_WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_data        (i_data),
    .i_commit      (i_commit),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_table_valid (o_table_valid),
    .o_weight0     (o_weight0),
    .o_weight1     (o_weight1),
    .o_weight2     (o_weight2),
    .o_weight3     (o_weight3),
    .o_weight4     (o_weight4),
    .o_weight5     (o_weight5),
    .o_weight6     (o_weight6),
    .o_weight7     (o_weight7)
  );

  assign w_s[0] = o_weight0;
  assign w_s[1] = o_weight1;
  assign w_s[2] = o_weight2;
  assign w_s[3] = o_weight3;
  assign w_s[4] = o_weight4;
  assign w_s[5] = o_weight5;
  assign w_s[6] = o_weight6;
  assign w_s[7] = o_weight7;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_active(input string tag, input logic [8*W-1:0] tbl);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_w%0d", tag, k), 32'(w_s[k]), 32'(tbl[k*W +: W]));
    end
  endtask

  // Drive an optional start and 8 beats with `gap` idle cycles before each beat
  task automatic load(input logic [8*W-1:0] vals, input int gap, input bit do_start);
    if (do_start) begin
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      for (int g = 0; g < gap; g++) begin
        i_valid = 1'b0;
        check("stall_ready", 32'(o_ready), 32'd1);
        tick();
      end
      i_valid = 1'b1;
      i_data  = vals[k*W +: W];
      check("beat_ready", 32'(o_ready), 32'd1);
      tick();
    end
    i_valid = 1'b0;
    check("pend_ready", 32'(o_ready), 32'd0);
    check("pend_busy", 32'(o_busy), 32'd1);
  endtask

  // Commit from PEND: expected table goes to the scoreboard, then direct timing checks
  task automatic commit(input logic [8*W-1:0] vals);
    i_commit = 1'b1;
    exp_q.push_back(vals);
    check_active("pre_commit", model);
    tick();
    i_commit = 1'b0;
    check("commit_done", 32'(o_done), 32'd1);
    check("commit_tvalid", 32'(o_table_valid), 32'd1);
    check("commit_busy", 32'(o_busy), 32'd0);
    model = vals;
    tick();
    check("done_one_cycle", 32'(o_done), 32'd0);
  endtask

  // Scoreboard consumer: each o_done pulse must match the oldest committed table
  always @(negedge clk) begin
    if (!rst && o_done === 1'b1) begin
      done_cnt++;
      check("done_has_expect", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check_active("sb", exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 8; k++) begin
      v1[k*W +: W] = W'(100 * (k + 1));
      v2[k*W +: W] = W'(5 + k);
      v3[k*W +: W] = 10'd1023;
      v5[k*W +: W] = W'(37 * k + 11);
    end
    v4 = {10'd1, 10'd700, 10'd17, 10'd1023, 10'd0, 10'd512, 10'd3, 10'd900};
    model = '0;

    rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_valid = 1'b0;
    i_commit = 1'b0; i_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_tvalid", 32'(o_table_valid), 32'd0);
    check_active("rst", '0);

    // Full-rate load of 100..800
    load(v1, 0, 1'b1);
    tick();
    check_active("pend_hold", '0);
    commit(v1);

    // Stalled load of 5..12
    load(v2, 3, 1'b1);
    commit(v2);

    // Commit gating: 1023 x8 sits in PEND, active table must not move
    load(v3, 0, 1'b1);
    for (int c = 0; c < 20; c++) begin
      check_active("gate", v2);
      check("gate_busy", 32'(o_busy), 32'd1);
      tick();
    end
    commit(v3);

    // Abort after 4 beats; abort also beats a concurrent valid beat
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1;
      i_data  = W'(k + 1);
      tick();
    end
    i_abort = 1'b1; i_valid = 1'b1; i_data = 10'd999;
    tick();
    i_abort = 1'b0; i_valid = 1'b0;
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_ready", 32'(o_ready), 32'd0);
    i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
    check("abort_no_done", 32'(o_done), 32'd0);
    check("abort_tvalid", 32'(o_table_valid), 32'd1);
    check_active("abort", model);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("restart_busy", 32'(o_busy), 32'd1);

    // Abort together with commit in PEND: no update, back to IDLE
    load(v4, 0, 1'b0);
    i_abort = 1'b1; i_commit = 1'b1;
    tick();
    i_abort = 1'b0; i_commit = 1'b0;
    check("abort_commit_done", 32'(o_done), 32'd0);
    check("abort_commit_busy", 32'(o_busy), 32'd0);
    check_active("abort_commit", model);

    // i_start during LOAD is ignored; the index keeps counting
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      i_start = (k == 3);
      i_valid = 1'b1;
      i_data  = v5[k*W +: W];
      check("mid_start_ready", 32'(o_ready), 32'd1);
      tick();
    end
    i_start = 1'b0; i_valid = 1'b0;
    check("mid_start_pend", 32'(o_ready), 32'd0);
    commit(v5);

    // Asynchronous reset while in PEND with a committed table
    load(v1, 0, 1'b1);
    rst = 1'b1;
    #2;
    check_active("async_rst", '0);
    check("async_rst_tvalid", 32'(o_table_valid), 32'd0);
    check("async_rst_ready", 32'(o_ready), 32'd0);
    check("async_rst_busy", 32'(o_busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model = '0;
    tick();
    check_active("post_rst", model);

    check("done_count", 32'(done_cnt), 32'd4);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
